dcache_2way: RTL

- 2-way set-associative, write-back, write-allocate data cache.
- Sits between the memory-stage address/data signals (ALUResultM, WriteDataM, MemWriteM, AddrModeM) and the 128-bit-line main memory.
- Hits return read data combinationally, in the same cycle, exactly as datamem does today.
- Misses assert stall until the line is written back if dirty, then refilled; the hazard unit freezes the pipeline while stall is high.

---
 rtl/dcache_2way.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dcache_2way.sv
// dcache_2way: 2-way set-associative, write-back, write-allocate data cache.
//   Hits return read_data combinationally in the same cycle. A miss raises
//   stall, writes the dirty victim back (if any), refills the line, and then
//   lets the held request re-evaluate as a hit.
// Ports:
//   clk, rst (sync, active-low)
//   data_address, write_data, MemRead, MemWrite, AddrMode : CPU request (AddrMode 1 = byte)
//   read_data, stall                                    : CPU response
//   mem_req, WriteEnable, memory_address, mem_writedata : memory request (WriteEnable 1 = writeback)
//   mem_readdata, mem_ready                             : memory response
// Optional build macro DCACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module dcache_2way #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  AddrMode,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] memory_address,
  output logic [127:0]          mem_writedata,
  input  logic [127:0]          mem_readdata,
  input  logic                  mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = DATA_WIDTH - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t state_q, state_d;
  logic   victim_q, victim_d;

  logic [1:0]       valid_q [SETS];
  logic [1:0]       dirty_q [SETS];
  logic             lru_q   [SETS];
  logic [TAG_W-1:0] tag_q   [2][SETS];
  logic [127:0]     line_q  [2][SETS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            wsel, bsel;
  logic                  req, hit, hw, victim_c, miss_start, fill;
  logic [1:0]            hit_way;
  logic [127:0]          sel_line, new_line;
  logic [DATA_WIDTH-1:0] sel_word, new_word;
  logic [7:0]            sel_byte;

  always_comb begin
    idx  = data_address[4+IDX_W-1:4];
    tag  = data_address[DATA_WIDTH-1:4+IDX_W];
    wsel = data_address[3:2];
    bsel = data_address[1:0];
    req  = MemRead | MemWrite;

    hit_way[0] = valid_q[idx][0] && (tag_q[0][idx] == tag);
    hit_way[1] = valid_q[idx][1] && (tag_q[1][idx] == tag);
    hit        = req && (state_q == IDLE) && (|hit_way);
    hw         = ~hit_way[0];

    sel_line = line_q[hw][idx];
    sel_word = sel_line[{wsel, 5'b0} +: DATA_WIDTH];
    sel_byte = sel_word[{bsel, 3'b0} +: 8];

    new_word = write_data;
    if (AddrMode) begin
      new_word = sel_word;
      new_word[{bsel, 3'b0} +: 8] = write_data[7:0];
    end
    new_line = sel_line;
    new_line[{wsel, 5'b0} +: DATA_WIDTH] = new_word;

    read_data = '0;
    if (hit && MemRead && !MemWrite)
      read_data = AddrMode ? {{(DATA_WIDTH-8){1'b0}}, sel_byte} : sel_word;

    // Fill invalid ways first, way0 before way1; otherwise the LRU way.
    if (!valid_q[idx][0])      victim_c = 1'b0;
    else if (!valid_q[idx][1]) victim_c = 1'b1;
    else                       victim_c = lru_q[idx];
  end

  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    stall          = 1'b0;
    mem_req        = 1'b0;
    WriteEnable    = 1'b0;
    memory_address = '0;
    mem_writedata  = '0;
    miss_start     = 1'b0;
    fill           = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !(|hit_way)) begin
          stall      = 1'b1;
          miss_start = 1'b1;
          victim_d   = victim_c;
          state_d    = (valid_q[idx][victim_c] && dirty_q[idx][victim_c]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        stall          = 1'b1;
        mem_req        = 1'b1;
        WriteEnable    = 1'b1;
        memory_address = {tag_q[victim_q][idx], idx, 4'b0};
        mem_writedata  = line_q[victim_q][idx];
        if (mem_ready) state_d = REFILL;
      end
      REFILL: begin
        stall          = 1'b1;
        mem_req        = 1'b1;
        memory_address = {tag, idx, 4'b0};
        if (mem_ready) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        lru_q[s]   <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (hit) begin
        lru_q[idx] <= ~hw;
        if (MemWrite) begin
          line_q[hw][idx]  <= new_line;
          dirty_q[idx][hw] <= 1'b1;
        end
      end
      if (fill) begin
        line_q[victim_q][idx]  <= mem_readdata;
        tag_q[victim_q][idx]   <= tag;
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        miss_pend_q, miss_pend_d;

  // miss_pend marks the post-fill hit so it is not counted as a first-time hit.
  always_comb begin
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    miss_pend_d = miss_pend_q;
    if (miss_start) begin
      miss_pend_d = 1'b1;
      if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
    end else if (hit) begin
      miss_pend_d = 1'b0;
      if (!miss_pend_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      miss_pend_q <= 1'b0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      miss_pend_q <= miss_pend_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
